// File: rtl/led_mode_controller_pkg.sv
// Shared definitions for the LED mode controller: mode encodings and small
// pure helpers used by the FSM and the LED mapping.
package led_mode_controller_pkg;

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_SLOW  = 3'd1;
  localparam logic [2:0] MODE_FAST  = 3'd2;
  localparam logic [2:0] MODE_ALT   = 3'd3;
  localparam logic [2:0] MODE_CHASE = 3'd4;

  // Successor in the press-driven mode ring; anything unexpected falls back to OFF.
  function automatic logic [2:0] mode_succ(input logic [2:0] m);
    logic [2:0] n;
    case (m)
      MODE_OFF:   n = MODE_SLOW;
      MODE_SLOW:  n = MODE_FAST;
      MODE_FAST:  n = MODE_ALT;
      MODE_ALT:   n = MODE_CHASE;
      MODE_CHASE: n = MODE_OFF;
      default:    n = MODE_OFF;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] chase_led(input logic [1:0] idx);
    logic [1:0] l;
    case (idx)
      2'd0:    l = 2'b01;
      2'd1:    l = 2'b10;
      default: l = 2'b00;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/led_mode_controller_btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted release-to-press transition.
module led_mode_controller_btn_debounce
  import led_mode_controller_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          deb_r;
  logic [CW-1:0] cnt_r;
  logic          press_r;
  logic          differ_s;
  logic          accept_s;

  assign differ_s = (sync2_r != deb_r);
  assign accept_s = differ_s && (cnt_r == CNT_LAST);

  // Synchronizer, debounce counter and press pulse. The synchronizer resets
  // high to match the debounced state, so a button held through reset is
  // never seen as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      deb_r   <= 1'b1;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= accept_s && sync2_r;
      if (accept_s) begin
        deb_r <= sync2_r;
        cnt_r <= '0;
      end else if (differ_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/led_mode_controller.sv
// Steps the two board LEDs through OFF/SLOW/FAST/ALT/CHASE blink patterns,
// one mode per debounced button press, timed by a shared two-stage prescaler.
module led_mode_controller
  import led_mode_controller_pkg::*;
#(
  parameter int FAST_DIV   = 12_500_000,
  parameter int SLOW_MULT  = 4,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [1:0] LED,
  output logic [2:0] mode,
  output logic       advance
);

  localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam int SW = (SLOW_MULT > 1) ? $clog2(SLOW_MULT) : 1;
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_MULT - 1);

  logic          advance_s;
  logic [FW-1:0] fast_cnt_r;
  logic [SW-1:0] slow_cnt_r;
  logic          fast_tick_s;
  logic          slow_tick_s;
  logic          p_fast_r;
  logic          p_slow_r;
  logic [1:0]    chase_idx_r;
  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [1:0]    led_nxt_s;
  logic [1:0]    led_r;

  led_mode_controller_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(advance_s)
  );

  assign fast_tick_s = (fast_cnt_r == FAST_LAST);
  assign slow_tick_s = fast_tick_s && (slow_cnt_r == SLOW_LAST);

  // Prescaler and pattern phase; a press restarts every pattern at phase 0
  // and swallows any tick landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || advance_s) begin
      fast_cnt_r  <= '0;
      slow_cnt_r  <= '0;
      p_fast_r    <= 1'b0;
      p_slow_r    <= 1'b0;
      chase_idx_r <= 2'd0;
    end else if (fast_tick_s) begin
      fast_cnt_r  <= '0;
      p_fast_r    <= ~p_fast_r;
      chase_idx_r <= (chase_idx_r == 2'd2) ? 2'd0 : chase_idx_r + 2'd1;
      if (slow_tick_s) begin
        slow_cnt_r <= '0;
        p_slow_r   <= ~p_slow_r;
      end else begin
        slow_cnt_r <= slow_cnt_r + SW'(1);
      end
    end else begin
      fast_cnt_r <= fast_cnt_r + FW'(1);
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MODE_OFF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next mode: step on a press; stray encodings recover to OFF unconditionally.
  always_comb begin
    state_nxt_s = MODE_OFF;
    case (state_r)
      MODE_OFF, MODE_SLOW, MODE_FAST, MODE_ALT, MODE_CHASE: begin
        if (advance_s) begin
          state_nxt_s = mode_succ(state_r);
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = MODE_OFF;
    endcase
  end

  // LED pattern selected by the current mode and phase bits.
  always_comb begin
    led_nxt_s = 2'b00;
    case (state_r)
      MODE_OFF:   led_nxt_s = 2'b00;
      MODE_SLOW:  led_nxt_s = {p_slow_r, p_slow_r};
      MODE_FAST:  led_nxt_s = {p_fast_r, p_fast_r};
      MODE_ALT:   led_nxt_s = {~p_slow_r, p_slow_r};
      MODE_CHASE: led_nxt_s = chase_led(chase_idx_r);
      default:    led_nxt_s = 2'b00;
    endcase
  end

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= 2'b00;
    end else begin
      led_r <= led_nxt_s;
    end
  end

  assign LED     = led_r;
  assign mode    = state_r;
  assign advance = advance_s;

endmodule

// File: tb/tb_led_mode_controller.sv
// Directed bench for led_mode_controller with small timing parameters; press
// pulses are scoreboarded by expected cycle, LEDs checked against elapsed-time arithmetic.
module tb_led_mode_controller;

  localparam int FD = 4;
  localparam int SM = 2;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [1:0] led;
  logic [2:0] mode;
  logic       advance;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int cur_mode = 0;
  int adv_q[$];

  led_mode_controller #(
    .FAST_DIV  (FD),
    .SLOW_MULT (SM),
    .DEB_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .LED    (led),
    .mode   (mode),
    .advance(advance)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected LED j cycles after the phase counters were cleared.
  function automatic logic [31:0] exp_led(input int m, input int j);
    int pf, ps, ci;
    pf = (j / FD) % 2;
    ps = (j / (FD * SM)) % 2;
    ci = (j / FD) % 3;
    case (m)
      1: return (ps != 0) ? 32'd3 : 32'd0;
      2: return (pf != 0) ? 32'd3 : 32'd0;
      3: return (ps != 0) ? 32'd1 : 32'd2;
      4: return (ci == 0) ? 32'd1 : ((ci == 1) ? 32'd2 : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_state(input string tag);
    int k;
    k = cyc - base;
    check({tag, "_mode"}, 32'(mode), 32'(cur_mode));
    if (k >= 1) check({tag, "_led"}, 32'(led), exp_led(cur_mode, k - 1));
  endtask

  // Clean press held 10 cycles; advance expected 2+DB cycles after the edge.
  task automatic run_press(input int new_mode, input int n);
    int c, nb;
    @(negedge clk);
    btn = 1'b1;
    c = cyc;
    adv_q.push_back(c + 2 + DB);
    nb = c + 3 + DB;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 9) btn = 1'b0;
      if (cyc >= nb) begin
        cur_mode = new_mode;
        base = nb;
        check_state("press");
      end
    end
  endtask

  // Time the press so advance lands in a cycle where the prescaler ticks.
  task automatic aligned_press(input int new_mode, input int modn, input int n);
    for (int i = 0; i <= modn; i++) begin
      if (((cyc + 1 + 2 + DB - base) % modn) == modn - 1) break;
      @(negedge clk);
    end
    run_press(new_mode, n);
  endtask

  // Advance scoreboard: each pulse must land exactly on its expected cycle.
  always @(negedge clk) begin
    if (adv_q.size() != 0 && adv_q[0] <= cyc) begin
      check("adv_pulse", 32'(advance), 32'd1);
      void'(adv_q.pop_front());
    end else if (advance === 1'b1) begin
      check("adv_spurious", 32'(advance), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_led", 32'(led), 32'd0);
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_adv", 32'(advance), 32'd0);
    end
    rst = 1'b0;
    base = cyc;
    @(negedge clk);
    check("post_rst_led", 32'(led), 32'd0);
    check("post_rst_mode", 32'(mode), 32'd0);
    check("post_rst_adv", 32'(advance), 32'd0);
    repeat (8) begin
      @(negedge clk);
      check_state("idle");
    end

    run_press(1, 24);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn = ~btn;
      check_state("bounce");
    end
    btn = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check_state("bounce_settle");
    end

    run_press(2, 20);
    run_press(3, 20);
    run_press(4, 24);
    run_press(0, 20);

    aligned_press(1, FD, 24);
    aligned_press(2, FD, 20);
    aligned_press(3, FD * SM, 24);

    run_press(4, 24);
    @(negedge clk);
    btn = 1'b1;
    rst = 1'b1;
    cur_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_mode", 32'(mode), 32'd0);
      check("midrst_led", 32'(led), 32'd0);
      check("midrst_adv", 32'(advance), 32'd0);
    end
    rst = 1'b0;
    base = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_state("held_after_rst");
      check("held_adv", 32'(advance), 32'd0);
    end
    btn = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check_state("release");
    end
    run_press(1, 20);

    check("adv_queue_empty", 32'(adv_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
